// File: rtl/jk_latch_driver.sv
// jk_latch_driver: command FIFO plus pulse/settle sequencer for a jk_latch.
// Define JK_DRV_CHECK_EN to compile in the expected-state checker.
module jk_latch_driver #(
   parameter int DEPTH   = 4,
   parameter int PULSE_W = 2,
   parameter int SETTLE  = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   output logic                   J,
   output logic                   K,
   output logic                   enable,
   input  logic                   Q,
   input  logic                   Q_bar,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_q,
   output logic                   rsp_err,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_RESP
   } state_t;

   state_t        state;
   logic [3:0]    tmr;
   logic [1:0]    mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [1:0]    head;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          capture;
   logic          chk_err;

   assign full      = count == (AW+1)'(DEPTH);
   assign empty     = count == '0;
   assign cmd_ready = !full && !rst;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == S_IDLE) && !empty;
   assign head      = mem[rptr];
   assign busy      = (state != S_IDLE) || !empty;
   assign capture   = (state == S_SETTLE) && (tmr == '0);

   // A full FIFO refuses pushes even when a pop frees a slot this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= cmd_op;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         tmr       <= '0;
         J         <= 1'b0;
         K         <= 1'b0;
         enable    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_q     <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (!empty) begin
                  {J, K} <= head;
                  enable <= 1'b1;
                  tmr    <= 4'(PULSE_W - 1);
                  state  <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               if (tmr == '0) begin
                  enable <= 1'b0;
                  tmr    <= 4'(SETTLE - 1);
                  state  <= S_SETTLE;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            S_SETTLE: begin
               if (tmr == '0) begin
                  rsp_q     <= Q;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  J         <= 1'b0;
                  K         <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef JK_DRV_CHECK_EN
   logic exp_v;
   logic exp_k;
   logic err_r;

   // Tracker advances at pop, then resyncs to the sampled Q at capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         exp_v <= 1'b0;
         exp_k <= 1'b0;
      end else if (pop) begin
         unique case (head)
            2'b01: begin
               exp_v <= 1'b0;
               exp_k <= 1'b1;
            end
            2'b10: begin
               exp_v <= 1'b1;
               exp_k <= 1'b1;
            end
            2'b11:   exp_v <= ~exp_v;
            default: ;
         endcase
      end else if (capture) begin
         exp_v <= Q;
      end
   end

   assign chk_err = (Q_bar == Q) || (exp_k && (Q != exp_v));

   always_ff @(posedge clk) begin
      if (rst)
         err_r <= 1'b0;
      else if (capture)
         err_r <= chk_err;
   end

   assign rsp_err = err_r;
`else
   logic unused_q_bar;

   assign chk_err      = 1'b0;
   assign unused_q_bar = Q_bar ^ chk_err ^ capture;
   assign rsp_err      = 1'b0;
`endif

endmodule
